// File: rtl/mul32_u_pkg.sv
// Shared widths and FSM encoding for the sequential 32x32 unsigned multiplier.
package mul32_u_pkg;

    localparam int OP_W  = 32;
    localparam int RES_W = 64;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        ST_LOAD = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/mul32_u_step.sv
// One radix-2 shift-and-add iteration: conditionally add the multiplicand into
// the high half, then shift the 65-bit {carry, acc} right by one.
module mul32_u_step
    import mul32_u_pkg::*;
(
    input  logic [RES_W-1:0] acc_i,
    input  logic [OP_W-1:0]  mcand_i,
    output logic [RES_W-1:0] acc_o
);

    logic [OP_W:0] addend;
    logic [OP_W:0] sum33;

    assign addend = acc_i[0] ? {1'b0, mcand_i} : '0;
    // Bit 32 of sum33 keeps the carry so FFFFFFFF*FFFFFFFF stays exact.
    assign sum33  = {1'b0, acc_i[RES_W-1:OP_W]} + addend;
    assign acc_o  = {sum33, acc_i[OP_W-1:1]};

endmodule

// File: rtl/mul32_u.sv
// Sequential 32x32 -> 64 unsigned multiplier; each reset release runs one
// multiplication (load + 32 iterations) and then holds the product.
//   state   | meaning
//   LOAD    | capture op1/op2 on first edge after release
//   RUN     | one partial product per clock, 32 iterations
//   DONE    | res/done held until next reset
module mul32_u
    import mul32_u_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [OP_W-1:0]  op1,
    input  logic [OP_W-1:0]  op2,
    output logic [RES_W-1:0] res,
    output logic             done
);

    state_e           state_q;
    logic [RES_W-1:0] acc_q;
    logic [RES_W-1:0] acc_d;
    logic [OP_W-1:0]  mcand_q;
    logic [CNT_W-1:0] cnt_q;
    logic [RES_W-1:0] res_q;
    logic             done_q;

    mul32_u_step u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .acc_o   (acc_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_LOAD;
            acc_q   <= '0;
            mcand_q <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    mcand_q <= op1;
                    acc_q   <= {{(RES_W-OP_W){1'b0}}, op2};
                    cnt_q   <= '0;
                    state_q <= ST_RUN;
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(OP_W-1)) begin
                        res_q   <= acc_d;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                end
                default: state_q <= ST_LOAD;
            endcase
        end
    end

    assign res  = res_q;
    assign done = done_q;

endmodule

// File: tb/tb_mul32_u.sv
// Scoreboard bench for mul32_u: expected products queued at reset release and
// compared after the 33rd edge.
module tb_mul32_u;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic [63:0] res;
    logic        done;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];

    always #5 clk = ~clk;

    mul32_u dut (
        .clk  (clk),
        .rst  (rst),
        .op1  (op1),
        .op2  (op2),
        .res  (res),
        .done (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_res", res, 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
    endtask

    // Reset, release with the given operands, walk 33 edges, then score.
    task automatic run_mul(input logic [31:0] a, input logic [31:0] b, input bit verbose);
        logic [63:0] prod;
        op1 = a;
        op2 = b;
        do_reset();
        rst  = 1'b1;
        prod = 64'(a) * 64'(b);
        exp_q.push_back(prod);
        for (int e = 1; e <= 33; e++) begin
            @(posedge clk);
            #1;
            if (e == 32 || (verbose && e < 33)) begin
                chk("pre_res", res, 64'd0);
                chk("pre_done", 64'(done), 64'd0);
            end
        end
        chk("res", res, exp_q.pop_front());
        chk("done", 64'(done), 64'd1);
    endtask

    initial begin
        #2;
        chk("init_res", res, 64'd0);
        chk("init_done", 64'(done), 64'd0);

        run_mul(32'h0000_0001, 32'hFFFF_FFFF, 1'b1);
        run_mul(32'h0000_0000, 32'h8000_0000, 1'b1);
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        chk("carry_const", res, 64'hFFFF_FFFE_0000_0001);

        run_mul(32'h8000_0000, 32'h0000_0002, 1'b0);
        chk("shift_const", res, 64'h0000_0001_0000_0000);
        op1 = 32'h1234_5678;
        op2 = 32'h9ABC_DEF0;
        repeat (5) @(posedge clk);
        #1;
        chk("hold_res", res, 64'h0000_0001_0000_0000);
        chk("hold_done", 64'(done), 64'd1);

        // Operand change mid-run, then asynchronous abort.
        op1 = 32'h0001_0000;
        op2 = 32'h0001_0000;
        do_reset();
        rst = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            @(posedge clk);
            #1;
            if (e == 5) op2 = 32'h0;
        end
        chk("mid_done", 64'(done), 64'd0);
        rst = 1'b0;
        #1;
        chk("abort_res", res, 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        run_mul(op1, op2, 1'b0);

        for (int i = 0; i < 1000; i++)
            run_mul($urandom, $urandom, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
